// File: rtl/ddr_bank_responder.sv
// DDR4 DRAM-side bank responder.
// Decodes ACT/PRE/RD/WR from the command pins and tracks the open/closed state
// and open row of each bank. It enforces tRCD, tRP and tRAS with per-bank
// down-counters and reports violations. Legal RD/WR commands produce a
// registered CAS event for the memory data model.
// Optional statistics counters are built only when DDR_BANK_RESP_STATS_EN is
// defined. Otherwise act_cnt/pre_cnt/cas_cnt are tied to zero.
// Each of TRCD, TRP and TRAS must lie in 1..2**TMR_W-1.
module ddr_bank_responder #(
   parameter int NUMBER_BANK = 16,
   parameter int RA_WIDTH    = 15,
   parameter int CA_WIDTH    = 10,
   parameter int TRCD        = 11,
   parameter int TRP         = 11,
   parameter int TRAS        = 28,
   parameter int TMR_W       = 6
) (
   input  logic                   clock_t,
   input  logic                   reset_n,
   input  logic                   cs_n,
   input  logic                   act_n,
   input  logic                   ras_n_a16,
   input  logic                   cas_n_a15,
   input  logic                   we_n_a14,
   input  logic [1:0]             bg_addr,
   input  logic [1:0]             ba_addr,
   input  logic [RA_WIDTH-1:0]    addr,
   output logic [NUMBER_BANK-1:0] bank_open,
   output logic                   cas_valid,
   output logic                   cas_rw,
   output logic [3:0]             cas_bank,
   output logic [RA_WIDTH-1:0]    cas_row,
   output logic [CA_WIDTH-1:0]    cas_col,
   output logic                   err_valid,
   output logic [2:0]             err_code,
   output logic [3:0]             err_bank,
   output logic [31:0]            act_cnt,
   output logic [31:0]            pre_cnt,
   output logic [31:0]            cas_cnt
);

   typedef enum logic [1:0] {B_IDLE, B_ACTIVE, B_PRECHG} bank_st_e;

   localparam logic [2:0] E_ACT_OPEN = 3'd1;
   localparam logic [2:0] E_ACT_TRP  = 3'd2;
   localparam logic [2:0] E_CAS_IDLE = 3'd3;
   localparam logic [2:0] E_CAS_TRCD = 3'd4;
   localparam logic [2:0] E_PRE_TRAS = 3'd5;

   bank_st_e             st_q   [NUMBER_BANK];
   bank_st_e             st_d   [NUMBER_BANK];
   logic [RA_WIDTH-1:0]  row_q  [NUMBER_BANK];
   logic [RA_WIDTH-1:0]  row_d  [NUMBER_BANK];
   logic [TMR_W-1:0]     trcd_q [NUMBER_BANK];
   logic [TMR_W-1:0]     trcd_d [NUMBER_BANK];
   logic [TMR_W-1:0]     tras_q [NUMBER_BANK];
   logic [TMR_W-1:0]     tras_d [NUMBER_BANK];
   logic [TMR_W-1:0]     trp_q  [NUMBER_BANK];
   logic [TMR_W-1:0]     trp_d  [NUMBER_BANK];

   logic                 cas_valid_q, cas_valid_d;
   logic                 cas_rw_q, cas_rw_d;
   logic [3:0]           cas_bank_q, cas_bank_d;
   logic [RA_WIDTH-1:0]  cas_row_q, cas_row_d;
   logic [CA_WIDTH-1:0]  cas_col_q, cas_col_d;
   logic                 err_valid_q, err_valid_d;
   logic [2:0]           err_code_q, err_code_d;
   logic [3:0]           err_bank_q, err_bank_d;

   logic                 cmd_act, cmd_pre, cmd_rd, cmd_wr, pre_all;
   logic [3:0]           cmd_bank;
   logic [2:0]           rcw;

   // Command decode. REF/MRS/ZQ and other encodings fall through as NOP.
   always_comb begin
      rcw      = {ras_n_a16, cas_n_a15, we_n_a14};
      cmd_bank = {bg_addr, ba_addr};
      cmd_act  = !cs_n && !act_n;
      cmd_pre  = !cs_n && act_n && (rcw == 3'b010);
      cmd_rd   = !cs_n && act_n && (rcw == 3'b101);
      cmd_wr   = !cs_n && act_n && (rcw == 3'b100);
      pre_all  = cmd_pre && addr[10];
   end

   // Per-bank next state, timer update, violation check and CAS event build.
   // Violation checks use the timer values registered before this edge, so a
   // timer that reaches 0 here makes the command legal.
   always_comb begin
      for (int i = 0; i < NUMBER_BANK; i++) begin
         st_d[i]   = st_q[i];
         row_d[i]  = row_q[i];
         trcd_d[i] = (trcd_q[i] != '0) ? trcd_q[i] - TMR_W'(1) : '0;
         tras_d[i] = (tras_q[i] != '0) ? tras_q[i] - TMR_W'(1) : '0;
         trp_d[i]  = (trp_q[i]  != '0) ? trp_q[i]  - TMR_W'(1) : '0;
         if (st_q[i] == B_PRECHG && trp_q[i] == '0) st_d[i] = B_IDLE;
      end
      cas_valid_d = 1'b0;
      cas_rw_d    = cas_rw_q;
      cas_bank_d  = cas_bank_q;
      cas_row_d   = cas_row_q;
      cas_col_d   = cas_col_q;
      err_valid_d = 1'b0;
      err_code_d  = err_code_q;
      err_bank_d  = err_bank_q;

      if (cmd_act) begin
         // A violating ACT still opens the new row.
         if (st_q[cmd_bank] == B_ACTIVE) begin
            err_valid_d = 1'b1;
            err_code_d  = E_ACT_OPEN;
            err_bank_d  = cmd_bank;
         end else if (trp_q[cmd_bank] != '0) begin
            err_valid_d = 1'b1;
            err_code_d  = E_ACT_TRP;
            err_bank_d  = cmd_bank;
         end
         st_d[cmd_bank]   = B_ACTIVE;
         row_d[cmd_bank]  = addr;
         trcd_d[cmd_bank] = TMR_W'(TRCD - 1);
         tras_d[cmd_bank] = TMR_W'(TRAS - 1);
      end

      if (cmd_pre) begin
         // Only ACTIVE banks are closed. PRE to a closed bank is a no-op.
         // The ascending scan reports the lowest violating bank.
         for (int i = 0; i < NUMBER_BANK; i++) begin
            if ((pre_all || cmd_bank == 4'(i)) && st_q[i] == B_ACTIVE) begin
               if (tras_q[i] != '0 && !err_valid_d) begin
                  err_valid_d = 1'b1;
                  err_code_d  = E_PRE_TRAS;
                  err_bank_d  = 4'(i);
               end
               st_d[i]  = B_PRECHG;
               trp_d[i] = TMR_W'(TRP - 1);
            end
         end
      end

      if (cmd_rd || cmd_wr) begin
         if (st_q[cmd_bank] != B_ACTIVE) begin
            err_valid_d = 1'b1;
            err_code_d  = E_CAS_IDLE;
            err_bank_d  = cmd_bank;
         end else if (trcd_q[cmd_bank] != '0) begin
            err_valid_d = 1'b1;
            err_code_d  = E_CAS_TRCD;
            err_bank_d  = cmd_bank;
         end else begin
            cas_valid_d = 1'b1;
            cas_rw_d    = cmd_wr;
            cas_bank_d  = cmd_bank;
            cas_row_d   = row_q[cmd_bank];
            cas_col_d   = addr[CA_WIDTH-1:0];
         end
      end
   end

   // Bank state, timers and registered outputs.
   always_ff @(posedge clock_t or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUMBER_BANK; i++) begin
            st_q[i]   <= B_IDLE;
            row_q[i]  <= '0;
            trcd_q[i] <= '0;
            tras_q[i] <= '0;
            trp_q[i]  <= '0;
         end
         cas_valid_q <= 1'b0;
         cas_rw_q    <= 1'b0;
         cas_bank_q  <= '0;
         cas_row_q   <= '0;
         cas_col_q   <= '0;
         err_valid_q <= 1'b0;
         err_code_q  <= '0;
         err_bank_q  <= '0;
      end else begin
         for (int i = 0; i < NUMBER_BANK; i++) begin
            st_q[i]   <= st_d[i];
            row_q[i]  <= row_d[i];
            trcd_q[i] <= trcd_d[i];
            tras_q[i] <= tras_d[i];
            trp_q[i]  <= trp_d[i];
         end
         cas_valid_q <= cas_valid_d;
         cas_rw_q    <= cas_rw_d;
         cas_bank_q  <= cas_bank_d;
         cas_row_q   <= cas_row_d;
         cas_col_q   <= cas_col_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
         err_bank_q  <= err_bank_d;
      end
   end

   // Open-row flags come straight from the bank state flops.
   always_comb begin
      for (int i = 0; i < NUMBER_BANK; i++) bank_open[i] = (st_q[i] == B_ACTIVE);
   end

   assign cas_valid = cas_valid_q;
   assign cas_rw    = cas_rw_q;
   assign cas_bank  = cas_bank_q;
   assign cas_row   = cas_row_q;
   assign cas_col   = cas_col_q;
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;
   assign err_bank  = err_bank_q;

`ifdef DDR_BANK_RESP_STATS_EN
   logic [31:0] act_cnt_q, pre_cnt_q, cas_cnt_q;

   // Statistics. ACT and PRE count once per command, violating or not.
   // CAS counts only legal RD/WR. All counters wrap naturally.
   always_ff @(posedge clock_t or negedge reset_n) begin
      if (!reset_n) begin
         act_cnt_q <= '0;
         pre_cnt_q <= '0;
         cas_cnt_q <= '0;
      end else begin
         if (cmd_act)     act_cnt_q <= act_cnt_q + 32'd1;
         if (cmd_pre)     pre_cnt_q <= pre_cnt_q + 32'd1;
         if (cas_valid_d) cas_cnt_q <= cas_cnt_q + 32'd1;
      end
   end

   assign act_cnt = act_cnt_q;
   assign pre_cnt = pre_cnt_q;
   assign cas_cnt = cas_cnt_q;
`else
   assign act_cnt = '0;
   assign pre_cnt = '0;
   assign cas_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr_bank_responder.sv
// Directed bench for ddr_bank_responder: timing boundaries, errors, PRE-all, reset.
module tb_ddr_bank_responder;

   logic        clock_t = 1'b0;
   logic        reset_n;
   logic        cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14;
   logic [1:0]  bg_addr, ba_addr;
   logic [14:0] addr;
   logic [15:0] bank_open;
   logic        cas_valid, cas_rw;
   logic [3:0]  cas_bank;
   logic [14:0] cas_row;
   logic [9:0]  cas_col;
   logic        err_valid;
   logic [2:0]  err_code;
   logic [3:0]  err_bank;
   logic [31:0] act_cnt, pre_cnt, cas_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   ddr_bank_responder dut (
      .clock_t(clock_t), .reset_n(reset_n), .cs_n(cs_n), .act_n(act_n),
      .ras_n_a16(ras_n_a16), .cas_n_a15(cas_n_a15), .we_n_a14(we_n_a14),
      .bg_addr(bg_addr), .ba_addr(ba_addr), .addr(addr),
      .bank_open(bank_open), .cas_valid(cas_valid), .cas_rw(cas_rw),
      .cas_bank(cas_bank), .cas_row(cas_row), .cas_col(cas_col),
      .err_valid(err_valid), .err_code(err_code), .err_bank(err_bank),
      .act_cnt(act_cnt), .pre_cnt(pre_cnt), .cas_cnt(cas_cnt)
   );

   always #5 clock_t = ~clock_t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic nop();
      cs_n = 1'b1; act_n = 1'b1; ras_n_a16 = 1'b1; cas_n_a15 = 1'b1; we_n_a14 = 1'b1;
      bg_addr = 2'd0; ba_addr = 2'd0; addr = '0;
   endtask

   // One clock edge; returns 1 time unit after it with the bus back to NOP.
   task automatic tick();
      @(posedge clock_t);
      #1;
      nop();
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic issue(input logic act, input logic [2:0] rcw, input logic [3:0] bank,
                        input logic [14:0] a);
      cs_n = 1'b0; act_n = ~act; {ras_n_a16, cas_n_a15, we_n_a14} = rcw;
      {bg_addr, ba_addr} = bank; addr = a;
      tick();
   endtask

   task automatic act_cmd(input logic [3:0] b, input logic [14:0] row);
      issue(1'b1, 3'b111, b, row);
   endtask
   task automatic pre_cmd(input logic [3:0] b, input logic all);
      issue(1'b0, 3'b010, b, all ? 15'h0400 : 15'h0000);
   endtask
   task automatic rd_cmd(input logic [3:0] b, input logic [14:0] col);
      issue(1'b0, 3'b101, b, col);
   endtask
   task automatic wr_cmd(input logic [3:0] b, input logic [14:0] col);
      issue(1'b0, 3'b100, b, col);
   endtask

   initial begin
      reset_n = 1'b0;
      nop();
      idle(2);
      chk("rst_bank_open", 32'(bank_open), 32'h0);
      chk("rst_cas_valid", 32'(cas_valid), 32'h0);
      chk("rst_err_valid", 32'(err_valid), 32'h0);
      chk("rst_act_cnt", act_cnt, 32'h0);
      reset_n = 1'b1;

      // tRCD boundary, legal read
      act_cmd(4'd5, 15'h1A2B);
      chk("act5_err", 32'(err_valid), 32'h0);
      chk("act5_open", 32'(bank_open), 32'h0020);
      idle(10);
      rd_cmd(4'd5, 15'h0040);
      chk("rd5_valid", 32'(cas_valid), 32'h1);
      chk("rd5_rw", 32'(cas_rw), 32'h0);
      chk("rd5_bank", 32'(cas_bank), 32'h5);
      chk("rd5_row", 32'(cas_row), 32'h1A2B);
      chk("rd5_col", 32'(cas_col), 32'h040);
      chk("rd5_err", 32'(err_valid), 32'h0);
      idle(1);
      chk("rd5_pulse", 32'(cas_valid), 32'h0);

      // tRCD violation one cycle early, then legal write
      act_cmd(4'd3, 15'h0333);
      idle(9);
      wr_cmd(4'd3, 15'h0011);
      chk("wr3_err", 32'(err_valid), 32'h1);
      chk("wr3_code", 32'(err_code), 32'h4);
      chk("wr3_ebank", 32'(err_bank), 32'h3);
      chk("wr3_nocas", 32'(cas_valid), 32'h0);
      wr_cmd(4'd3, 15'h0012);
      chk("wr3b_valid", 32'(cas_valid), 32'h1);
      chk("wr3b_rw", 32'(cas_rw), 32'h1);
      chk("wr3b_row", 32'(cas_row), 32'h0333);
      chk("wr3b_err", 32'(err_valid), 32'h0);

      // tRAS boundary on bank 0
      act_cmd(4'd0, 15'h0100);
      idle(26);
      pre_cmd(4'd0, 1'b0);
      chk("pre0_err", 32'(err_valid), 32'h1);
      chk("pre0_code", 32'(err_code), 32'h5);
      chk("pre0_ebank", 32'(err_bank), 32'h0);
      chk("pre0_closed", 32'(bank_open[0]), 32'h0);
      idle(10);
      act_cmd(4'd0, 15'h0101);
      chk("act0_err", 32'(err_valid), 32'h0);
      idle(27);
      pre_cmd(4'd0, 1'b0);
      chk("pre0b_err", 32'(err_valid), 32'h0);
      chk("pre0b_closed", 32'(bank_open[0]), 32'h0);

      // tRP boundary and ACT to an open bank on bank 2
      act_cmd(4'd2, 15'h0200);
      idle(27);
      pre_cmd(4'd2, 1'b0);
      chk("pre2_err", 32'(err_valid), 32'h0);
      idle(9);
      act_cmd(4'd2, 15'h0201);
      chk("act2_code", 32'(err_code), 32'h2);
      chk("act2_err", 32'(err_valid), 32'h1);
      chk("act2_open", 32'(bank_open[2]), 32'h1);
      act_cmd(4'd2, 15'h0202);
      chk("act2b_code", 32'(err_code), 32'h1);
      chk("act2b_ebank", 32'(err_bank), 32'h2);
      idle(27);
      pre_cmd(4'd2, 1'b0);
      chk("pre2b_err", 32'(err_valid), 32'h0);
      idle(10);
      act_cmd(4'd2, 15'h0203);
      chk("act2c_err", 32'(err_valid), 32'h0);
      chk("act2c_open", 32'(bank_open[2]), 32'h1);

      // PRE to an idle bank must not load tRP
      pre_cmd(4'd9, 1'b0);
      chk("pre9_err", 32'(err_valid), 32'h0);
      act_cmd(4'd9, 15'h0900);
      chk("act9_err", 32'(err_valid), 32'h0);

      // PRE-all after tRAS, then RD to a closed bank
      act_cmd(4'd1, 15'h0011);
      act_cmd(4'd7, 15'h0077);
      act_cmd(4'd12, 15'h00CC);
      idle(27);
      pre_cmd(4'd0, 1'b1);
      chk("preall_err", 32'(err_valid), 32'h0);
      chk("preall_open", 32'(bank_open), 32'h0);
      rd_cmd(4'd7, 15'h0005);
      chk("rd7_code", 32'(err_code), 32'h3);
      chk("rd7_ebank", 32'(err_bank), 32'h7);
      chk("rd7_nocas", 32'(cas_valid), 32'h0);

      // PRE-all violation reports lowest bank
      act_cmd(4'd6, 15'h0066);
      act_cmd(4'd4, 15'h0044);
      pre_cmd(4'd15, 1'b1);
      chk("preall2_code", 32'(err_code), 32'h5);
      chk("preall2_ebank", 32'(err_bank), 32'h4);
      chk("preall2_open", 32'(bank_open), 32'h0);

      // Reset mid tRCD wait
      act_cmd(4'd10, 15'h0AAA);
      idle(3);
      reset_n = 1'b0;
      #2;
      chk("mrst_open", 32'(bank_open), 32'h0);
      chk("mrst_cas_bank", 32'(cas_bank), 32'h0);
      chk("mrst_cas_row", 32'(cas_row), 32'h0);
      chk("mrst_err_code", 32'(err_code), 32'h0);
      chk("mrst_act_cnt", act_cnt, 32'h0);
      chk("mrst_cas_cnt", cas_cnt, 32'h0);
      chk("mrst_pre_cnt", pre_cnt, 32'h0);
      #3;
      reset_n = 1'b1;
      idle(1);
      chk("post_rst_err", 32'(err_valid), 32'h0);
      rd_cmd(4'd10, 15'h0001);
      chk("rd10_code", 32'(err_code), 32'h3);
      chk("rd10_ebank", 32'(err_bank), 32'hA);
      chk("rd10_nocas", 32'(cas_valid), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
